// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM tile arbiter.
// Holds the arbiter state encoding and a one-hot to index helper.
//
// Contents
//   arb_state_t    : IDLE -> LOAD -> EXEC -> WAIT -> IDLE
//   MAX_REQ        : widest request vector onehot_to_idx accepts
//   onehot_to_idx  : index of the set bit of a one-hot vector
//                    (highest set bit wins if more than one is set,
//                    0 for an all-zero vector)
package cim_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOAD,
        ARB_EXEC,
        ARB_WAIT
    } arb_state_t;

    localparam int MAX_REQ = 32;

    function automatic int onehot_to_idx(
        input logic [MAX_REQ-1:0] v
    );
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cim_tile_arbiter_rr_picker.sv
// Combinational round-robin picker for the CIM tile arbiter.
// Selects the first set request bit strictly after ptr, wrapping.
//
// Parameters
//   num_req : number of requesters (>= 2)
// Ports
//   req   in  num_req          request vector
//   ptr   in  clog2(num_req)   last served requester
//   gnt   out num_req          one-hot winner (0 when no request)
//   valid out 1                a winner exists
module rr_picker #(
    parameter int num_req = 4
) (
    input  logic [num_req-1:0]         req,
    input  logic [$clog2(num_req)-1:0] ptr,
    output logic [num_req-1:0]         gnt,
    output logic                       valid
);

    // Distance from ptr is tried 1..num_req, so ptr itself is
    // the last candidate; the first hit along that walk wins.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int off = 1; off <= num_req; off++) begin
            for (int k = 0; k < num_req; k++) begin
                if (!valid && req[k] &&
                    ((int'(ptr) + off) % num_req) == k) begin
                    gnt[k] = 1'b1;
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cim_tile_arbiter.sv
// Shares one CIM crossbar tile between several layer controllers:
// grant, input-load burst, MVM start, wait for tile, done, repeat.
//
// Optional feature macro: CIM_ARB_TIMEOUT_EN
//   defined   : LOAD watchdog; after timeout_cycles LOAD cycles with
//               no load_done the owner is dropped and o_err sticks.
//   undefined : LOAD waits indefinitely, o_err is tied 0.
//
// Parameters
//   num_req        requesting controllers (>= 2)
//   datatype_size  width of one input element
//   xbar_size      crossbar rows (address = clog2(xbar_size) bits)
//   timeout_cycles LOAD watchdog limit
// Ports
//   clk          in  1           clock, posedge
//   rst          in  1           synchronous reset, active low
//   i_req        in  num_req     requests, held until o_done
//   i_we         in  num_req     per-requester write enable
//   i_addr       in  num_req x A per-requester row address
//   i_data       in  num_req x D per-requester write data
//   i_load_done  in  num_req     owner's last write this cycle
//   o_gnt        out num_req     registered one-hot grant
//   o_done       out num_req     one-cycle completion pulse
//   o_cim_we     out 1           tile write enable
//   o_cim_addr   out A           tile row address
//   o_cim_data   out D           tile write data
//   o_cim_start  out 1           one-cycle MVM start
//   i_cim_busy   in  1           tile computing
//   o_busy       out 1           arbiter not idle
//   o_err        out 1           sticky LOAD watchdog flag
module cim_tile_arbiter
    import cim_pkg::*;
#(
    parameter int num_req        = 4,
    parameter int datatype_size  = 8,
    parameter int xbar_size      = 256,
    parameter int timeout_cycles = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [num_req-1:0]             i_req,
    input  logic [num_req-1:0]             i_we,
    input  logic [num_req-1:0]
                 [$clog2(xbar_size)-1:0]   i_addr,
    input  logic [num_req-1:0]
                 [datatype_size-1:0]       i_data,
    input  logic [num_req-1:0]             i_load_done,
    output logic [num_req-1:0]             o_gnt,
    output logic [num_req-1:0]             o_done,
    output logic                           o_cim_we,
    output logic [$clog2(xbar_size)-1:0]   o_cim_addr,
    output logic [datatype_size-1:0]       o_cim_data,
    output logic                           o_cim_start,
    input  logic                           i_cim_busy,
    output logic                           o_busy,
    output logic                           o_err
);

    localparam int PW = $clog2(num_req);
    localparam int AW = $clog2(xbar_size);
    localparam int DW = datatype_size;

    localparam logic [num_req-1:0] ONE =
        {{(num_req-1){1'b0}}, 1'b1};

    // Elaboration-time guard on the configuration.
    if (num_req < 2 || num_req > MAX_REQ ||
        timeout_cycles < 1) begin : g_bad_cfg
        $error("cim_tile_arbiter: bad parameters");
    end

    arb_state_t         state_q, state_n;
    logic [PW-1:0]      owner_q, owner_n;
    logic [PW-1:0]      ptr_q, ptr_n;
    logic [num_req-1:0] gnt_q, gnt_n;
    logic               first_q, first_n;

    logic [num_req-1:0] pick_gnt;
    logic               pick_valid;
    logic [num_req-1:0] owner_oh;
    logic               timeout;

    rr_picker #(
        .num_req (num_req)
    ) u_picker (
        .req   (i_req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign owner_oh = ONE << owner_q;

`ifdef CIM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles) + 1;

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Counts LOAD cycles; zero in the first cycle of every LOAD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q != ARB_LOAD) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A load_done in the final allowed cycle still wins.
    assign timeout = (state_q == ARB_LOAD) &&
                     !i_load_done[owner_q] &&
                     (cnt_q == CW'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= PW'(num_req - 1);
            gnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            gnt_q   <= gnt_n;
            first_q <= first_n;
        end
    end

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        gnt_n   = gnt_q;
        first_n = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid && !i_cim_busy) begin
                    gnt_n   = pick_gnt;
                    owner_n = PW'(onehot_to_idx(
                                  MAX_REQ'(pick_gnt)));
                    state_n = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                if (i_load_done[owner_q]) begin
                    gnt_n   = '0;
                    state_n = ARB_EXEC;
                end else if (!i_req[owner_q] || timeout) begin
                    // Abandoned burst: no start, owner goes
                    // to the back of the rotation.
                    gnt_n   = '0;
                    ptr_n   = owner_q;
                    state_n = ARB_IDLE;
                end
            end
            ARB_EXEC: begin
                first_n = 1'b1;
                state_n = ARB_WAIT;
            end
            ARB_WAIT: begin
                // The tile raises busy a cycle after start, so
                // busy is only trusted from the second cycle on.
                if (!first_q && !i_cim_busy) begin
                    ptr_n   = owner_q;
                    state_n = ARB_IDLE;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    assign o_gnt       = gnt_q;
    assign o_busy      = (state_q != ARB_IDLE);
    assign o_cim_start = (state_q == ARB_EXEC);

    // Gated by rst so a reset landing in WAIT never leaks a done.
    assign o_done = (rst && state_q == ARB_WAIT &&
                     !first_q && !i_cim_busy) ?
                    owner_oh : '0;

    assign o_cim_we   = (state_q == ARB_LOAD) && i_we[owner_q];
    assign o_cim_addr = o_cim_we ? i_addr[owner_q] : '0;
    assign o_cim_data = o_cim_we ? i_data[owner_q] : '0;

endmodule

// File: tb/tb_cim_tile_arbiter.sv
// Scoreboard bench for cim_tile_arbiter: directed stimulus pushes
// expected grant/write/start/done/err events, a monitor pops them.
module tb_cim_tile_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 8;

    localparam logic [2:0] K_GNT   = 3'd1;
    localparam logic [2:0] K_WR    = 3'd2;
    localparam logic [2:0] K_START = 3'd3;
    localparam logic [2:0] K_DONE  = 3'd4;
    localparam logic [2:0] K_ERR   = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          i_req;
    logic [N-1:0]          i_we;
    logic [N-1:0][AW-1:0]  i_addr;
    logic [N-1:0][DW-1:0]  i_data;
    logic [N-1:0]          i_load_done;
    logic [N-1:0]          o_gnt;
    logic [N-1:0]          o_done;
    logic                  o_cim_we;
    logic [AW-1:0]         o_cim_addr;
    logic [DW-1:0]         o_cim_data;
    logic                  o_cim_start;
    logic                  i_cim_busy;
    logic                  o_busy;
    logic                  o_err;

    ev_t          exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [N-1:0] prev_gnt = '0;
    logic         prev_err = 1'b0;

    always #5 clk = ~clk;

    cim_tile_arbiter #(
        .num_req        (N),
        .datatype_size  (DW),
        .xbar_size      (256),
        .timeout_cycles (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_load_done (i_load_done),
        .o_gnt       (o_gnt),
        .o_done      (o_done),
        .o_cim_we    (o_cim_we),
        .o_cim_addr  (o_cim_addr),
        .o_cim_data  (o_cim_data),
        .o_cim_start (o_cim_start),
        .i_cim_busy  (i_cim_busy),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [2:0] k,
                             input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [2:0] k,
                           input logic [15:0] v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected event: got kind=%0d val=%0h",
                     k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                bad++;
                $display("FAIL event: got kind=%0d val=%0h want kind=%0d val=%0h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from updates.
    initial begin
        forever begin
            @(negedge clk);
            check("gnt_onehot", {31'b0, $onehot0(o_gnt)}, 32'd1);
            check("start_with_gnt",
                  {31'b0, o_cim_start && (|o_gnt)}, 32'd0);
            if (o_gnt != '0 && o_gnt != prev_gnt)
                observe(K_GNT, {12'b0, o_gnt});
            if (o_cim_we)
                observe(K_WR, {o_cim_addr, o_cim_data});
            if (o_cim_start)
                observe(K_START, 16'h0);
            if (o_done != '0)
                observe(K_DONE, {12'b0, o_done});
            if (o_err && !prev_err)
                observe(K_ERR, 16'h0);
            prev_gnt = o_gnt;
            prev_err = o_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        i_req       = '0;
        i_we        = '0;
        i_addr      = '0;
        i_data      = '0;
        i_load_done = '0;
        i_cim_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_gnt(input logic [1:0] idx);
        bit seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (o_gnt[idx]) seen = 1'b1;
        end
        check("gnt_arrives", {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_done(input logic [1:0] idx);
        bit seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (c != 0) @(negedge clk);
            else @(negedge clk);
            if (o_done[idx]) seen = 1'b1;
        end
        check("done_arrives", {31'b0, seen}, 32'd1);
    endtask

    // Full transaction for requester idx, whose request must
    // already be high: grant, nwr writes, start, done.
    task automatic burst(input logic [1:0] idx,
                         input int nwr,
                         input logic [7:0] a0,
                         input logic [7:0] d0,
                         input logic [N-1:0] drop);
        logic [N-1:0] oh;
        oh = 4'b0001 << idx;
        expect_ev(K_GNT, {12'b0, oh});
        for (int k = 0; k < nwr; k++)
            expect_ev(K_WR, {a0 + 8'(k), d0 + 8'(k)});
        expect_ev(K_START, 16'h0);
        expect_ev(K_DONE, {12'b0, oh});
        wait_gnt(idx);
        for (int k = 0; k < nwr; k++) begin
            @(posedge clk);
            #1;
            i_we[idx]        = 1'b1;
            i_addr[idx]      = a0 + 8'(k);
            i_data[idx]      = d0 + 8'(k);
            i_load_done[idx] = (k == nwr - 1);
        end
        @(posedge clk);
        #1;
        i_we[idx]        = 1'b0;
        i_load_done[idx] = 1'b0;
        i_cim_busy       = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_cim_busy = 1'b0;
        wait_done(idx);
        @(posedge clk);
        #1;
        i_req = i_req & ~drop;
    endtask

    initial begin
        rst         = 1'b0;
        i_req       = '0;
        i_we        = '0;
        i_addr      = '0;
        i_data      = '0;
        i_load_done = '0;
        i_cim_busy  = 1'b0;
        do_reset();

        @(negedge clk);
        check("rst_gnt", {28'b0, o_gnt}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_we", {31'b0, o_cim_we}, 32'd0);
        check("rst_start", {31'b0, o_cim_start}, 32'd0);
        check("rst_err", {31'b0, o_err}, 32'd0);

        // Single requester, three writes.
        @(posedge clk);
        #1;
        i_req = 4'b0001;
        @(negedge clk);
        check("gnt_latency", {28'b0, o_gnt}, 32'd0);
        burst(2'd0, 3, 8'h00, 8'h11, 4'b0001);

        // All requesting: strict rotation 0,1,2,3,0.
        do_reset();
        i_req = 4'b1111;
        burst(2'd0, 1, 8'h10, 8'hA0, 4'b0000);
        burst(2'd1, 2, 8'h20, 8'hB0, 4'b0000);
        burst(2'd2, 1, 8'h30, 8'hC0, 4'b0000);
        burst(2'd3, 1, 8'h40, 8'hD0, 4'b0000);
        burst(2'd0, 1, 8'h50, 8'hE0, 4'b1111);

        // Tile busy blocks arbitration.
        @(posedge clk);
        #1;
        i_cim_busy = 1'b1;
        i_req      = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            check("busy_blocks", {28'b0, o_gnt}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_cim_busy = 1'b0;
        @(negedge clk);
        check("busy_release", {28'b0, o_gnt}, 32'd0);
        burst(2'd1, 1, 8'h60, 8'h33, 4'b0010);

        // Owner 2 abandons its burst; 3 is next.
        @(posedge clk);
        #1;
        i_req = 4'b1100;
        expect_ev(K_GNT, 16'h0004);
        expect_ev(K_WR, {8'h05, 8'h55});
        wait_gnt(2'd2);
        @(posedge clk);
        #1;
        i_we      = 4'b1100;
        i_addr[2] = 8'h05;
        i_data[2] = 8'h55;
        i_addr[3] = 8'h09;
        i_data[3] = 8'hAA;
        @(posedge clk);
        #1;
        i_we      = '0;
        i_req[2]  = 1'b0;
        i_addr[2] = 8'h07;
        i_data[2] = 8'h77;
        @(negedge clk);
        check("idle_addr", {24'b0, o_cim_addr}, 32'd0);
        check("idle_data", {24'b0, o_cim_data}, 32'd0);
        check("abort_gnt_held", {28'b0, o_gnt}, 32'h4);
        @(negedge clk);
        check("abort_gnt", {28'b0, o_gnt}, 32'd0);
        check("abort_busy", {31'b0, o_busy}, 32'd0);
        burst(2'd3, 2, 8'h70, 8'h80, 4'b1000);

        // Reset during WAIT: no done, outputs clear.
        @(posedge clk);
        #1;
        i_req = 4'b0001;
        expect_ev(K_GNT, 16'h0001);
        expect_ev(K_WR, {8'h30, 8'h21});
        expect_ev(K_START, 16'h0);
        wait_gnt(2'd0);
        @(posedge clk);
        #1;
        i_we[0]        = 1'b1;
        i_addr[0]      = 8'h30;
        i_data[0]      = 8'h21;
        i_load_done[0] = 1'b1;
        @(posedge clk);
        #1;
        i_we[0]        = 1'b0;
        i_load_done[0] = 1'b0;
        i_cim_busy     = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("wait_busy", {31'b0, o_busy}, 32'd1);
        @(negedge clk);
        check("mid_rst_busy", {31'b0, o_busy}, 32'd0);
        check("mid_rst_gnt", {28'b0, o_gnt}, 32'd0);
        check("mid_rst_done", {28'b0, o_done}, 32'd0);
        check("mid_rst_start", {31'b0, o_cim_start}, 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        i_cim_busy = 1'b0;
        i_req      = 4'b0011;
        burst(2'd0, 1, 8'h90, 8'h44, 4'b0011);

`ifdef CIM_ARB_TIMEOUT_EN
        // Owner never signals load_done.
        begin
            int n;
            bit hit;
            n   = 0;
            hit = 1'b0;
            @(posedge clk);
            #1;
            i_req = 4'b0100;
            expect_ev(K_GNT, 16'h0004);
            expect_ev(K_ERR, 16'h0);
            wait_gnt(2'd2);
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge clk);
                n++;
                if (o_err) hit = 1'b1;
            end
            check("timeout_cycles", n, 32'd8);
            check("timeout_gnt", {28'b0, o_gnt}, 32'd0);
            check("timeout_busy", {31'b0, o_busy}, 32'd0);
            @(posedge clk);
            #1;
            i_req = '0;
            repeat (3) @(negedge clk);
            check("err_sticky", {31'b0, o_err}, 32'd1);
        end
`else
        check("err_tied", {31'b0, o_err}, 32'd0);
`endif

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
